// File: rtl/board_scanner.sv
// rtl/board_scanner.sv - streams a snapshotted 16-cell board plus score as valid/ready beats
//
// Purpose: on start (in IDLE) capture the board and score, emit one beat per cell
// (index + log2 exponent) and then a final score beat, and publish per-frame
// statistics (highest legal exponent, empty-cell count, malformed-cell flag)
// when the score beat is accepted.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   board, score     live game state, sampled only on the capture edge
//   start            scan request, honoured only in IDLE
//   out_ready        consumer accepts the current beat
//   out_valid        beat present
//   out_index        cell index (0 on the score beat)
//   out_exp          cell exponent (0 on the score beat, 31 for malformed cells)
//   out_is_score     beat carries the score; also the last beat of the frame
//   out_score        snapshotted score on the score beat, otherwise 0
//   busy             frame in progress
//   done             one-cycle pulse after the score beat is accepted
//   max_exp          largest legal exponent of the last frame
//   empty_count      zero cells in the last frame
//   bad_cell         last frame contained a malformed cell

module board_scanner #(
  parameter int CELL_W  = 20,
  parameter int SCORE_W = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [16*CELL_W-1:0] board,
  input  logic [SCORE_W-1:0]   score,
  input  logic                 start,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [3:0]           out_index,
  output logic [4:0]           out_exp,
  output logic                 out_is_score,
  output logic [SCORE_W-1:0]   out_score,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           max_exp,
  output logic [4:0]           empty_count,
  output logic                 bad_cell
);

  typedef enum logic [1:0] {IDLE, LOAD, TILE, SCORE} state_t;

  localparam logic [4:0] EXP_BAD = 5'd31;

  // Exponent of a tile value: 0 for empty, k for a single set bit at k >= 1,
  // EXP_BAD for the value 1 or any multi-bit value.
  function automatic logic [4:0] cell_exp(input logic [CELL_W-1:0] v);
    logic [4:0] pos;
    pos = '0;
    for (int i = 0; i < CELL_W; i++) begin
      if (v[i]) pos = 5'(i);
    end
    if (v == '0) begin
      return 5'd0;
    end else if (((v & (v - CELL_W'(1))) == '0) && (v != CELL_W'(1))) begin
      return pos;
    end else begin
      return EXP_BAD;
    end
  endfunction

  state_t               state_q, state_d;
  logic [16*CELL_W-1:0] snap_board_q, snap_board_d;
  logic [SCORE_W-1:0]   snap_score_q, snap_score_d;

  logic                 out_valid_q, out_valid_d;
  logic [3:0]           out_index_q, out_index_d;
  logic [4:0]           out_exp_q, out_exp_d;
  logic                 out_is_score_q, out_is_score_d;
  logic [SCORE_W-1:0]   out_score_q, out_score_d;

  logic [4:0]           acc_max_q, acc_max_d;
  logic [4:0]           acc_empty_q, acc_empty_d;
  logic                 acc_bad_q, acc_bad_d;

  logic                 done_q, done_d;
  logic [4:0]           max_exp_q, max_exp_d;
  logic [4:0]           empty_count_q, empty_count_d;
  logic                 bad_cell_q, bad_cell_d;

  // Cell to present next: cell 0 from LOAD, otherwise the one after the
  // current beat. Only consumed when load_cell is asserted.
  logic [3:0]           load_idx;
  logic [CELL_W-1:0]    load_val;
  logic [4:0]           load_exp;
  logic                 load_cell;
  logic                 xfer;

  assign load_idx = (state_q == LOAD) ? 4'd0 : 4'(out_index_q + 4'd1);
  assign load_val = snap_board_q[CELL_W*load_idx +: CELL_W];
  assign load_exp = cell_exp(load_val);
  assign xfer     = out_valid_q && out_ready;

  always_comb begin
    state_d        = state_q;
    snap_board_d   = snap_board_q;
    snap_score_d   = snap_score_q;
    out_valid_d    = out_valid_q;
    out_index_d    = out_index_q;
    out_exp_d      = out_exp_q;
    out_is_score_d = out_is_score_q;
    out_score_d    = out_score_q;
    acc_max_d      = acc_max_q;
    acc_empty_d    = acc_empty_q;
    acc_bad_d      = acc_bad_q;
    done_d         = 1'b0;
    max_exp_d      = max_exp_q;
    empty_count_d  = empty_count_q;
    bad_cell_d     = bad_cell_q;
    load_cell      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_board_d = board;
          snap_score_d = score;
          acc_max_d    = '0;
          acc_empty_d  = '0;
          acc_bad_d    = 1'b0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        load_cell = 1'b1;
        state_d   = TILE;
      end
      TILE: begin
        if (xfer) begin
          if (out_index_q == 4'd15) begin
            out_index_d    = '0;
            out_exp_d      = '0;
            out_is_score_d = 1'b1;
            out_score_d    = snap_score_q;
            state_d        = SCORE;
          end else begin
            load_cell = 1'b1;
          end
        end
      end
      SCORE: begin
        if (xfer) begin
          out_valid_d    = 1'b0;
          out_is_score_d = 1'b0;
          out_score_d    = '0;
          max_exp_d      = acc_max_q;
          empty_count_d  = acc_empty_q;
          bad_cell_d     = acc_bad_q;
          done_d         = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Statistics accumulate as each cell beat is loaded into the output stage.
    if (load_cell) begin
      out_valid_d    = 1'b1;
      out_index_d    = load_idx;
      out_exp_d      = load_exp;
      out_is_score_d = 1'b0;
      out_score_d    = '0;
      if (load_exp == 5'd0) begin
        acc_empty_d = acc_empty_q + 5'd1;
      end else if (load_exp == EXP_BAD) begin
        acc_bad_d = 1'b1;
      end else if (load_exp > acc_max_q) begin
        acc_max_d = load_exp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      snap_board_q   <= '0;
      snap_score_q   <= '0;
      out_valid_q    <= 1'b0;
      out_index_q    <= '0;
      out_exp_q      <= '0;
      out_is_score_q <= 1'b0;
      out_score_q    <= '0;
      acc_max_q      <= '0;
      acc_empty_q    <= '0;
      acc_bad_q      <= 1'b0;
      done_q         <= 1'b0;
      max_exp_q      <= '0;
      empty_count_q  <= '0;
      bad_cell_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      snap_board_q   <= snap_board_d;
      snap_score_q   <= snap_score_d;
      out_valid_q    <= out_valid_d;
      out_index_q    <= out_index_d;
      out_exp_q      <= out_exp_d;
      out_is_score_q <= out_is_score_d;
      out_score_q    <= out_score_d;
      acc_max_q      <= acc_max_d;
      acc_empty_q    <= acc_empty_d;
      acc_bad_q      <= acc_bad_d;
      done_q         <= done_d;
      max_exp_q      <= max_exp_d;
      empty_count_q  <= empty_count_d;
      bad_cell_q     <= bad_cell_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_index    = out_index_q;
  assign out_exp      = out_exp_q;
  assign out_is_score = out_is_score_q;
  assign out_score    = out_score_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign max_exp      = max_exp_q;
  assign empty_count  = empty_count_q;
  assign bad_cell     = bad_cell_q;

endmodule

// File: tb/tb_board_scanner.sv
// tb/tb_board_scanner.sv - scoreboard bench for board_scanner with a behavioural frame model

module tb_board_scanner;

  localparam int CW = 20;
  localparam int SW = 21;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [16*CW-1:0]  board = '0;
  logic [SW-1:0]     score = '0;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [3:0]        out_index;
  logic [4:0]        out_exp;
  logic              out_is_score;
  logic [SW-1:0]     out_score;
  logic              busy;
  logic              done;
  logic [4:0]        max_exp;
  logic [4:0]        empty_count;
  logic              bad_cell;

  board_scanner #(.CELL_W(CW), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .board(board), .score(score), .start(start),
    .out_ready(out_ready), .out_valid(out_valid), .out_index(out_index),
    .out_exp(out_exp), .out_is_score(out_is_score), .out_score(out_score),
    .busy(busy), .done(done), .max_exp(max_exp), .empty_count(empty_count),
    .bad_cell(bad_cell)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int ex;
    int is_score;
    int sc;
  } beat_t;

  typedef struct {
    int mx;
    int emp;
    int bad;
  } stat_t;

  beat_t beat_q[$];
  stat_t stat_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int xfers = 0;
  bit ready_mode = 1'b0;
  bit prev_stall = 1'b0;
  beat_t prev_b;
  int prev_v;

  task automatic chk(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Exponent from the arithmetic definition: log2 of a power of two >= 2.
  function automatic int ref_exp(input logic [CW-1:0] v);
    if (v == 0) return 0;
    if ($countones(v) == 1 && v != 1) return $clog2(v);
    return 31;
  endfunction

  task automatic push_frame(input logic [16*CW-1:0] b, input logic [SW-1:0] s);
    stat_t st;
    beat_t bt;
    st.mx = 0; st.emp = 0; st.bad = 0;
    for (int i = 0; i < 16; i++) begin
      int e;
      e = ref_exp(b[i*CW +: CW]);
      bt.idx = i; bt.ex = e; bt.is_score = 0; bt.sc = 0;
      beat_q.push_back(bt);
      if (e == 0) st.emp++;
      else if (e == 31) st.bad = 1;
      else if (e > st.mx) st.mx = e;
    end
    bt.idx = 0; bt.ex = 0; bt.is_score = 1; bt.sc = int'(s);
    beat_q.push_back(bt);
    stat_q.push_back(st);
  endtask

  function automatic logic [16*CW-1:0] rand_board();
    logic [16*CW-1:0] b;
    logic [CW-1:0] v;
    b = '0;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: v = '0;
        1: v = CW'(1) << $urandom_range(1, CW - 1);
        2: v = CW'($urandom);
        default: v = CW'(1);
      endcase
      b[i*CW +: CW] = v;
    end
    return b;
  endfunction

  // Ready driver: always-ready or 50% random, changed just after each edge.
  always begin
    @(posedge clk);
    #1;
    out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: sampled mid-cycle; a transfer happens on the next rising edge.
  always @(negedge clk) begin
    beat_t e;
    stat_t s;
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, prev_v);
        chk("stall_index", out_index, prev_b.idx);
        chk("stall_exp", out_exp, prev_b.ex);
        chk("stall_is_score", out_is_score, prev_b.is_score);
        chk("stall_score", out_score, prev_b.sc);
      end
      prev_stall = out_valid && !out_ready;
      prev_v = out_valid;
      prev_b.idx = out_index; prev_b.ex = out_exp;
      prev_b.is_score = out_is_score; prev_b.sc = int'(out_score);
      if (out_valid && out_ready) begin
        xfers++;
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = beat_q.pop_front();
          chk("beat_index", out_index, e.idx);
          chk("beat_exp", out_exp, e.ex);
          chk("beat_is_score", out_is_score, e.is_score);
          chk("beat_score", out_score, e.sc);
        end
      end
      if (done) begin
        chk("done_busy", busy, 0);
        if (stat_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          s = stat_q.pop_front();
          chk("stat_max_exp", max_exp, s.mx);
          chk("stat_empty_count", empty_count, s.emp);
          chk("stat_bad_cell", bad_cell, s.bad);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_index"}, out_index, 0);
    chk({tag, "_out_exp"}, out_exp, 0);
    chk({tag, "_out_is_score"}, out_is_score, 0);
    chk({tag, "_out_score"}, out_score, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_max_exp"}, max_exp, 0);
    chk({tag, "_empty_count"}, empty_count, 0);
    chk({tag, "_bad_cell"}, bad_cell, 0);
  endtask

  task automatic issue_start(input logic [16*CW-1:0] b, input logic [SW-1:0] s);
    board = b;
    score = s;
    start = 1'b1;
    push_frame(b, s);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    while (stat_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    chk("frame_timeout", stat_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [16*CW-1:0] b;
    int base;
    int n;

    // Asynchronous reset asserted mid-cycle.
    #3 rst = 1'b1;
    #1 check_reset("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic frame with out_ready held high, exact latency.
    ready_mode = 1'b0;
    tick();
    b = '0;
    b[0*CW +: CW] = 2;
    b[5*CW +: CW] = 4;
    issue_start(b, 12);
    tick();
    chk("first_valid", out_valid, 1);
    chk("first_index", out_index, 0);
    chk("first_exp", out_exp, 1);
    repeat (16) tick();
    chk("done_early", done, 0);
    tick();
    chk("done_at_n18", done, 1);
    chk("busy_at_n18", busy, 0);
    chk("basic_empty", empty_count, 14);
    chk("basic_max", max_exp, 2);
    chk("basic_bad", bad_cell, 0);

    // Conversion edges, started in the done cycle (back-to-back).
    b = '0;
    b[3*CW +: CW] = 6;
    b[7*CW +: CW] = 1;
    b[15*CW +: CW] = 20'h80000;
    issue_start(b, 777);
    tick();
    chk("b2b_first_valid", out_valid, 1);
    wait_frame_done();
    chk("edge_bad", bad_cell, 1);
    chk("edge_max", max_exp, 19);
    chk("edge_empty", empty_count, 13);

    // Backpressure with random frames.
    ready_mode = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_idle();
      issue_start(rand_board(), SW'($urandom));
      wait_frame_done();
    end

    // Snapshot isolation and ignored mid-frame start.
    wait_idle();
    base = xfers;
    issue_start(rand_board(), SW'($urandom));
    n = 0;
    while (xfers == base && n < 200) begin
      tick();
      n++;
    end
    chk("snap_first_beat", xfers > base, 1);
    for (int i = 0; i < 16; i++) board[i*CW +: CW] = 8;
    score = 99;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_frame_done();
    repeat (5) tick();
    chk("no_queued_start", busy, 0);

    // Reset after five transfers.
    wait_idle();
    base = xfers;
    issue_start(rand_board(), SW'($urandom));
    n = 0;
    while (xfers < base + 5 && n < 500) begin
      tick();
      n++;
    end
    chk("five_transfers", xfers - base, 5);
    #1 rst = 1'b1;
    #1 check_reset("mid");
    beat_q.delete();
    stat_q.delete();
    prev_stall = 1'b0;
    #1 rst = 1'b0;
    tick();
    issue_start(rand_board(), SW'($urandom));
    wait_frame_done();

    repeat (20) tick();
    chk("beats_left", beat_q.size(), 0);
    chk("stats_left", stat_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
